// File: rtl/clock_ctrl.sv
// Programmable clock divider with halt/drain/phase-delay sequencing. Optional single-step
// input enabled by CLOCK_CTRL_STEP_EN; START_HALTED=1 keeps HALT after reset until hlt is seen high.
module clock_ctrl #(
  parameter int DIV_W        = 16,
  parameter int DEF_PERIOD   = 4,
  parameter int DEF_HIGH     = 2,
  parameter int PHASE_DLY    = 0,
  parameter int START_HALTED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hlt,
  input  logic             cfg_ld,
  input  logic [DIV_W-1:0] period_in,
  input  logic [DIV_W-1:0] high_in,
`ifdef CLOCK_CTRL_STEP_EN
  input  logic             step,
`endif
  output logic             cclk,
  output logic             cclk_rise,
  output logic             cclk_fall,
  output logic             halted
);

  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] p);
    if (p < DIV_W'(2)) return DIV_W'(2);
    else return p;
  endfunction

  function automatic logic [DIV_W-1:0] eff_high(input logic [DIV_W-1:0] p_eff,
                                                input logic [DIV_W-1:0] h);
    if (h < DIV_W'(1)) return DIV_W'(1);
    else if (h > p_eff - DIV_W'(1)) return p_eff - DIV_W'(1);
    else return h;
  endfunction

  logic [1:0]       st_q, st_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d, hi_q, hi_d;
  logic [DIV_W-1:0] sper_q, sper_d, shi_q, shi_d;
  logic             cclk_q, cclk_d, rise_q, rise_d, fall_q, fall_d;
  logic             halted_q, halted_d;
  logic             hold_q, hold_d, step_q, step_d;
  logic             step_s, wrap_s, dly_end_s, load_s, run_s, halt_req_s;

`ifdef CLOCK_CTRL_STEP_EN
  assign step_s = step;
`else
  assign step_s = 1'b0;
`endif

  assign wrap_s     = (cnt_q == per_q - DIV_W'(1));
  assign dly_end_s  = (cnt_q == DIV_W'(PHASE_DLY - 1));
  assign halt_req_s = hlt | step_q;

  // Next-state, counter, shadow and active period/high computation.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    step_d = step_q;
    load_s = 1'b0;
    if (cfg_ld) begin
      sper_d = period_in;
      shi_d  = high_in;
    end else begin
      sper_d = sper_q;
      shi_d  = shi_q;
    end
    case (st_q)
      ST_HALT: begin
        cnt_d  = '0;
        load_s = 1'b1;
        if (hlt) hold_d = 1'b0;
        else     hold_d = hold_q;
        if ((!hlt && !hold_q) || (hlt && step_s)) begin
          step_d = hlt & step_s;
          if (PHASE_DLY > 0) st_d = ST_DELAY;
          else               st_d = ST_RUN;
        end else begin
          st_d = ST_HALT;
        end
      end
      ST_DELAY: begin
        load_s = 1'b1;
        if (hlt && !step_q) begin
          st_d  = ST_HALT;
          cnt_d = '0;
        end else if (dly_end_s) begin
          st_d  = ST_RUN;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_RUN, ST_DRAIN: begin
        // The halt decision is taken at the wrap so a period is never cut short.
        if (wrap_s) begin
          cnt_d  = '0;
          load_s = 1'b1;
          if (halt_req_s) begin
            st_d   = ST_HALT;
            step_d = 1'b0;
          end else begin
            st_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (halt_req_s) st_d = ST_DRAIN;
          else            st_d = ST_RUN;
        end
      end
      default: begin
        st_d  = ST_HALT;
        cnt_d = '0;
      end
    endcase
    if (load_s) begin
      per_d = eff_period(sper_d);
      hi_d  = eff_high(eff_period(sper_d), shi_d);
    end else begin
      per_d = per_q;
      hi_d  = hi_q;
    end
  end

  // Output values are derived from the next state so they register glitch-free.
  always_comb begin
    run_s    = (st_d == ST_RUN) || (st_d == ST_DRAIN);
    cclk_d   = run_s && (cnt_d < hi_d);
    rise_d   = cclk_d & ~cclk_q;
    fall_d   = ~cclk_d & cclk_q;
    halted_d = (st_d == ST_HALT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= ST_HALT;
      cnt_q    <= '0;
      sper_q   <= DIV_W'(DEF_PERIOD);
      shi_q    <= DIV_W'(DEF_HIGH);
      per_q    <= eff_period(DIV_W'(DEF_PERIOD));
      hi_q     <= eff_high(eff_period(DIV_W'(DEF_PERIOD)), DIV_W'(DEF_HIGH));
      cclk_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      halted_q <= 1'b1;
      hold_q   <= (START_HALTED != 0);
      step_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      sper_q   <= sper_d;
      shi_q    <= shi_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      cclk_q   <= cclk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      halted_q <= halted_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
    end
  end

  assign cclk      = cclk_q;
  assign cclk_rise = rise_q;
  assign cclk_fall = fall_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: default instance checked against a period-waveform reference model,
// a PHASE_DLY=3 / START_HALTED=1 instance checked with directed expectations.
module tb_clock_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hlt0 = 1'b0, hlt1 = 1'b1, cfg_ld = 1'b0;
  logic [15:0] period_in = 16'd4, high_in = 16'd2;
  logic        step0 = 1'b0, step1 = 1'b0;
  logic        cclk0, rise0, fall0, halted0;
  logic        cclk1, rise1, fall1, halted1;
  int          total = 0, bad = 0;

  // reference model state: the remaining cclk values of the current period
  bit          pend[$];
  int          shp = 4, shh = 2, cur_p = 0;
  bit          m_run = 0, prev = 0, cur = 0;
  bit          e_cclk = 0, e_rise = 0, e_fall = 0, e_halt = 1;

  always #5 clk = ~clk;

  clock_ctrl dut0 (
    .clk(clk), .rst(rst), .hlt(hlt0), .cfg_ld(cfg_ld), .period_in(period_in), .high_in(high_in),
`ifdef CLOCK_CTRL_STEP_EN
    .step(step0),
`endif
    .cclk(cclk0), .cclk_rise(rise0), .cclk_fall(fall0), .halted(halted0));

  clock_ctrl #(.PHASE_DLY(3), .START_HALTED(1)) dut1 (
    .clk(clk), .rst(rst), .hlt(hlt1), .cfg_ld(1'b0), .period_in(16'd0), .high_in(16'd0),
`ifdef CLOCK_CTRL_STEP_EN
    .step(step1),
`endif
    .cclk(cclk1), .cclk_rise(rise1), .cclk_fall(fall1), .halted(halted1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    shp = 4; shh = 2; m_run = 0; prev = 0;
    e_cclk = 0; e_rise = 0; e_fall = 0; e_halt = 1;
  endtask

  // one clk edge of the reference: a period is a fixed waveform, and at each period
  // boundary (or while halted) hlt sampled at that edge decides whether the next one starts
  task automatic model_edge();
    int pe, he;
    if (rst) begin
      model_reset();
    end else begin
      if (cfg_ld) begin
        shp = int'(period_in);
        shh = int'(high_in);
      end
      if (pend.size() == 0) begin
        if (!hlt0) begin
          pe = (shp < 2) ? 2 : shp;
          he = (shh < 1) ? 1 : ((shh > pe - 1) ? pe - 1 : shh);
          cur_p = pe;
          for (int i = 0; i < pe; i++) pend.push_back(i < he);
          m_run = 1;
        end else begin
          m_run = 0;
        end
      end
      cur    = m_run ? pend.pop_front() : 1'b0;
      e_rise = cur && !prev;
      e_fall = !cur && prev;
      prev   = cur;
      e_cclk = cur;
      e_halt = !m_run;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("d0_cclk", cclk0, e_cclk);
    chk("d0_rise", rise0, e_rise);
    chk("d0_fall", fall0, e_fall);
    chk("d0_halted", halted0, e_halt);
  endtask

  initial begin
    bit found;
    int nr, nf;

    // reset values
    @(negedge clk); @(negedge clk);
    chk("rst_cclk0", cclk0, 0); chk("rst_rise0", rise0, 0); chk("rst_fall0", fall0, 0);
    chk("rst_halted0", halted0, 1); chk("rst_cclk1", cclk1, 0); chk("rst_halted1", halted1, 1);
    rst = 1'b0;

    // defaults: 1,1,0,0 repeating
    for (int i = 0; i < 12; i++) tick();

    // reconfigure mid-period to 5/1
    tick();
    cfg_ld = 1'b1; period_in = 16'd5; high_in = 16'd1;
    tick();
    cfg_ld = 1'b0;
    for (int i = 0; i < 15; i++) tick();

    // back to 4/2, then halt requested with cnt==1
    cfg_ld = 1'b1; period_in = 16'd4; high_in = 16'd2;
    tick();
    cfg_ld = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_run && cur_p == 4 && pend.size() == 2) found = 1;
    end
    chk("wait_cnt1", found, 1);
    hlt0 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("halt_hold_cclk", cclk0, 0);
    chk("halt_hold_halted", halted0, 1);

    // degenerate config 0/9 -> P=2,H=1
    cfg_ld = 1'b1; period_in = 16'd0; high_in = 16'd9;
    tick();
    cfg_ld = 1'b0; hlt0 = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // phase-delayed instance: released, then rise exactly 4 edges after hlt drops
    hlt1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("d1_halted", halted1, 0);
      chk("d1_rise", rise1, (k == 4) ? 1 : 0);
      chk("d1_cclk", cclk1, (k == 4) ? 1 : 0);
    end
    hlt1 = 1'b1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (halted1) found = 1;
    end
    chk("d1_drain_done", found, 1);
    // hlt pulse during DELAY aborts with no edge
    hlt1 = 1'b0;
    tick();
    chk("d1_delay_halted", halted1, 0);
    hlt1 = 1'b1;
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nr += int'(rise1) + int'(cclk1);
    end
    chk("d1_abort_halted", halted1, 1);
    chk("d1_abort_no_edge", nr, 0);

`ifdef CLOCK_CTRL_STEP_EN
    // single step while halted
    step1 = 1'b1;
    tick();
    step1 = 1'b0;
    nr = 0; nf = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      nr += int'(rise1);
      nf += int'(fall1);
    end
    chk("step_rises", nr, 1);
    chk("step_falls", nf, 1);
    chk("step_halted", halted1, 1);
`endif

    // randomized phase on the default instance
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) hlt0 = ~hlt0;
      if ($urandom_range(0, 9) == 0) begin
        cfg_ld = 1'b1;
        period_in = 16'($urandom_range(0, 7));
        high_in = 16'($urandom_range(0, 8));
      end else begin
        cfg_ld = 1'b0;
      end
      tick();
    end

    // asynchronous reset in the middle of a high phase
    cfg_ld = 1'b0; hlt0 = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (e_rise) found = 1;
    end
    chk("wait_rise", found, 1);
    rst = 1'b1;
    #1;
    chk("arst_cclk", cclk0, 0);
    chk("arst_rise", rise0, 0);
    chk("arst_halted", halted0, 1);
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
